// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the frame-buffer double-buffer scheduler.
//   state_t      : scheduler sequence IDLE -> CLEAR -> PROCESS -> WAIT_VSYNC -> SWAP
//   bank_t       : frame-buffer bank select encoding
//   other_bank() : the bank that is not the given one (back bank of a front bank)
package fb_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_PROCESS    = 3'd2,
    ST_WAIT_VSYNC = 3'd3,
    ST_SWAP       = 3'd4
  } state_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_t;

  localparam int unsigned FB_WORDS_DEFAULT    = 307200;  // 640x480
  localparam logic [7:0]  CLEAR_VALUE_DEFAULT = 8'h00;
  localparam bank_t       DISPLAY_BANK_RESET  = BANK_A;

  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/frame_swap_scheduler_if.sv
// Processor and frame-buffer write-port bundle of the scheduler.
//   master : scheduler side (drives proc_enable and the fb_* write port,
//            receives the processor's done flag and write stream)
//   slave  : processor / frame-buffer side
interface frame_swap_scheduler_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);

  logic              proc_enable;
  logic              proc_done;
  logic              proc_wren;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_data;
  logic              fb_wren;
  logic              fb_wr_bank;
  logic [ADDR_W-1:0] fb_wraddr;
  logic [DATA_W-1:0] fb_data;

  modport master (
    output proc_enable, fb_wren, fb_wr_bank, fb_wraddr, fb_data,
    input  proc_done, proc_wren, proc_addr, proc_data
  );

  modport slave (
    input  proc_enable, fb_wren, fb_wr_bank, fb_wraddr, fb_data,
    output proc_done, proc_wren, proc_addr, proc_data
  );

endinterface

// File: rtl/vsync_edge_sync.sv
// Brings the raw active-low VGA vsync into the local clock domain and flags
// the start of vertical sync (falling edge of the synchronized level).
//   i_clk     : local clock
//   i_rst     : asynchronous active-high reset (chain resets to "vsync inactive")
//   i_vsync_n : raw vsync from the pixel-clock domain
//   o_fall    : one-cycle pulse on a synchronized 1 -> 0 transition
module vsync_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync_n,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= i_vsync_n;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_fall = r_sync_d & ~r_sync;

endmodule

// File: rtl/frame_swap_scheduler.sv
// Double-buffer manager for the VGA frame buffer. Each run clears the back
// bank, lets the image processor draw into it, waits for vertical sync and
// then swaps front and back banks.
//   CLOCK_50     : system clock
//   reset        : asynchronous, active-high
//   start_req    : one-cycle run request (one request may queue while busy)
//   vsync_n      : raw VGA vsync, active-low, pixel-clock domain
//   bus          : processor enable/done/write stream and frame-buffer write port
//   display_bank : front bank read by the VGA path
//   busy         : scheduler not idle
//   swap_done    : pulse in the swap cycle
//   req_dropped  : pulse when a request arrives with one already queued
//   error        : sticky timeout / out-of-range write, cleared on accepted start
module frame_swap_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 19,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FB_WORDS    = FB_WORDS_DEFAULT,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(CLEAR_VALUE_DEFAULT),
  parameter int unsigned       TIMEOUT     = 2000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start_req,
  input  logic                   vsync_n,
  frame_swap_scheduler_if.master bus,
  output logic                   display_bank,
  output logic                   busy,
  output logic                   swap_done,
  output logic                   req_dropped,
  output logic                   error
);

  localparam int unsigned       WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT);

  state_t            r_state;
  logic              r_pending;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [WD_W-1:0]   r_wd;
  bank_t             r_display_bank;
  logic              r_busy;
  logic              r_proc_en;
  logic              r_req_dropped;
  logic              r_error;

  state_t            w_next;
  logic              w_pend_next;
  logic              w_drop;
  logic              w_accept;
  logic              w_oor;
  logic              w_timeout;
  logic              w_vs_fall;
  logic              w_addr_ok;
  logic              w_fb_wren;
  logic [ADDR_W-1:0] w_fb_addr;
  logic [DATA_W-1:0] w_fb_data;

  vsync_edge_sync u_vsync (
    .i_clk     (CLOCK_50),
    .i_rst     (reset),
    .i_vsync_n (vsync_n),
    .o_fall    (w_vs_fall)
  );

  assign w_addr_ok = (bus.proc_addr <= LAST_ADDR);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pend_next = r_pending;
    w_drop      = 1'b0;
    w_accept    = 1'b0;
    w_oor       = 1'b0;
    w_timeout   = 1'b0;
    w_fb_wren   = 1'b0;
    w_fb_addr   = '0;
    w_fb_data   = '0;

    // Queue depth is one: a second request while busy is discarded.
    if (r_state != ST_IDLE && start_req) begin
      if (r_pending) w_drop      = 1'b1;
      else           w_pend_next = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (start_req || r_pending) begin
          w_next      = ST_CLEAR;
          w_pend_next = 1'b0;
          w_accept    = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_fb_wren = 1'b1;
        w_fb_addr = r_clr_cnt;
        w_fb_data = CLEAR_VALUE;
        if (r_clr_cnt == LAST_ADDR) w_next = ST_PROCESS;
      end
      ST_PROCESS: begin
        // Zero-latency passthrough; out-of-range writes never reach the RAM.
        w_fb_addr = bus.proc_addr;
        w_fb_data = bus.proc_data;
        if (bus.proc_wren) begin
          if (w_addr_ok) w_fb_wren = 1'b1;
          else           w_oor     = 1'b1;
        end
        if (bus.proc_done) begin
          w_next = ST_WAIT_VSYNC;
        end else if (r_wd >= WD_LAST) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_WAIT_VSYNC: begin
        if (w_vs_fall) w_next = ST_SWAP;
      end
      ST_SWAP: begin
        // w_pend_next already includes a request arriving in this cycle.
        if (w_pend_next) begin
          w_next      = ST_CLEAR;
          w_pend_next = 1'b0;
          w_accept    = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_pending      <= 1'b0;
      r_clr_cnt      <= '0;
      r_wd           <= '0;
      r_display_bank <= DISPLAY_BANK_RESET;
      r_busy         <= 1'b0;
      r_proc_en      <= 1'b0;
      r_req_dropped  <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_pending     <= w_pend_next;
      r_busy        <= (w_next != ST_IDLE);
      r_proc_en     <= (w_next == ST_PROCESS);
      r_req_dropped <= w_drop;

      if (w_accept)                r_error <= 1'b0;
      else if (w_oor || w_timeout) r_error <= 1'b1;

      // Counter restarts at 0 whenever CLEAR is (re)entered.
      if (r_state == ST_CLEAR && w_next == ST_CLEAR) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      else                                           r_clr_cnt <= '0;

      if (r_state == ST_PROCESS && w_next == ST_PROCESS) begin
        if (r_wd != WD_MAX) r_wd <= r_wd + WD_W'(1);
      end else begin
        r_wd <= '0;
      end

      if (r_state == ST_SWAP) r_display_bank <= other_bank(r_display_bank);
    end
  end

  assign bus.proc_enable = r_proc_en;
  assign bus.fb_wren     = w_fb_wren;
  assign bus.fb_wraddr   = w_fb_addr;
  assign bus.fb_data     = w_fb_data;
  assign bus.fb_wr_bank  = other_bank(r_display_bank);
  assign display_bank    = r_display_bank;
  assign busy            = r_busy;
  assign swap_done       = (r_state == ST_SWAP);
  assign req_dropped     = r_req_dropped;
  assign error           = r_error;

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Bench for frame_swap_scheduler: small frame (16 words), short watchdog (50).
module tb_frame_swap_scheduler;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int FBW = 16;
  localparam int TMO = 50;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic start_req = 1'b0;
  logic vsync_n   = 1'b1;
  logic display_bank, busy, swap_done, req_dropped, error;

  frame_swap_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_swap_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .CLEAR_VALUE(8'h00), .TIMEOUT(TMO)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .start_req    (start_req),
    .vsync_n      (vsync_n),
    .bus          (bus),
    .display_bank (display_bank),
    .busy         (busy),
    .swap_done    (swap_done),
    .req_dropped  (req_dropped),
    .error        (error)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_CLEAR, M_PROCESS, M_WAIT, M_SWAP} mphase_t;
  typedef struct {
    mphase_t  ph;
    int       clr;    // word being cleared this cycle
    int       wd;     // PROCESS cycles spent so far
    bit       pend;
    bit       err;
    bit       disp;
    bit       drop;   // req_dropped visible this cycle
    bit [2:0] vhist;  // vsync_n sampled 1,2,3 edges ago
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.ph = M_IDLE; r.clr = 0; r.wd = 0; r.pend = 0; r.err = 0;
    r.disp = 0; r.drop = 0; r.vhist = 3'b111;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, bit sreq, bit done, bit wren, int addr, bit vs);
    model_t n = s;
    // vsync start as seen locally: two-sample delayed level going 1 -> 0
    bit fall = s.vhist[2] && !s.vhist[1];
    n.vhist = {s.vhist[1:0], vs};
    n.drop = 0;
    if (s.ph != M_IDLE && sreq) begin
      if (s.pend) n.drop = 1;
      else        n.pend = 1;
    end
    case (s.ph)
      M_IDLE: if (sreq || s.pend) begin
        n.ph = M_CLEAR; n.clr = 0; n.pend = 0; n.err = 0;
      end
      M_CLEAR: if (s.clr == FBW - 1) begin n.ph = M_PROCESS; n.wd = 0; end
               else n.clr = s.clr + 1;
      M_PROCESS: begin
        if (wren && addr >= FBW) n.err = 1;
        n.wd = s.wd + 1;
        if (done) n.ph = M_WAIT;
        else if (n.wd == TMO) begin n.ph = M_IDLE; n.err = 1; end
      end
      M_WAIT: if (fall) n.ph = M_SWAP;
      M_SWAP: begin
        n.disp = !s.disp;
        if (n.pend) begin n.ph = M_CLEAR; n.clr = 0; n.pend = 0; n.err = 0; end
        else n.ph = M_IDLE;
      end
      default: n.ph = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [20:0] model_out(model_t s, bit wren, logic [4:0] addr, logic [7:0] data);
    bit         pe = (s.ph == M_PROCESS);
    bit         fw = 0;
    logic [4:0] fa = '0;
    logic [7:0] fd = '0;
    if (s.ph == M_CLEAR) begin
      fw = 1; fa = 5'(s.clr); fd = 8'h00;
    end else if (pe) begin
      fw = wren && (addr < FBW); fa = addr; fd = data;
    end
    return {pe, fw, !s.disp, fa, fd, s.disp, s.ph != M_IDLE, s.ph == M_SWAP, s.drop, s.err};
  endfunction

  model_t m;
  logic [20:0] dut_out;
  assign dut_out = {bus.proc_enable, bus.fb_wren, bus.fb_wr_bank, bus.fb_wraddr, bus.fb_data,
                    display_bank, busy, swap_done, req_dropped, error};

  initial begin
    m = model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m = model_reset();
      else m = model_step(m, start_req, bus.proc_done, bus.proc_wren, int'(bus.proc_addr), vsync_n);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("outputs", 32'(dut_out), 32'(model_out(m, bus.proc_wren, bus.proc_addr, bus.proc_data)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(inout int d, inout int s);
    @(negedge clk);
    if (req_dropped) d++;
    if (swap_done)   s++;
    tick();
  endtask

  int drops, swaps, pcyc, first_idle, vper, vcnt;

  initial begin
    bus.proc_done = 1'b0; bus.proc_wren = 1'b0; bus.proc_addr = '0; bus.proc_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_display_bank", display_bank, 0);
    chk("rst_fb_wr_bank", bus.fb_wr_bank, 1);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    tick(); reset = 1'b0;
    tick();

    // run 1: clear then process
    start_req = 1'b1; tick(); start_req = 1'b0;
    for (int i = 0; i < FBW; i++) begin
      @(negedge clk);
      chk("clear_wren", bus.fb_wren, 1);
      chk("clear_addr", bus.fb_wraddr, i);
      chk("clear_data", bus.fb_data, 8'h00);
      chk("clear_bank", bus.fb_wr_bank, 1);
      chk("clear_proc_enable", bus.proc_enable, 0);
      tick();
    end
    @(negedge clk);
    chk("proc_enable_c17", bus.proc_enable, 1);
    tick();
    bus.proc_wren = 1'b1; bus.proc_addr = 5'd5; bus.proc_data = 8'hA7;
    @(negedge clk);
    chk("pass_wren", bus.fb_wren, 1);
    chk("pass_addr", bus.fb_wraddr, 5);
    chk("pass_data", bus.fb_data, 8'hA7);
    tick(); bus.proc_wren = 1'b0;

    drops = 0; swaps = 0;
    for (int k = 0; k < 3; k++) begin
      start_req = 1'b1; obs(drops, swaps);
      start_req = 1'b0; obs(drops, swaps);
    end
    obs(drops, swaps);
    chk("req_dropped_count", drops, 2);

    bus.proc_wren = 1'b1; bus.proc_addr = 5'd16; bus.proc_data = 8'h55;
    @(negedge clk);
    chk("oor_wren", bus.fb_wren, 0);
    tick(); bus.proc_wren = 1'b0;
    @(negedge clk);
    chk("oor_error", error, 1);
    tick();
    bus.proc_done = 1'b1; tick(); bus.proc_done = 1'b0;
    @(negedge clk);
    chk("wait_error_sticky", error, 1);
    chk("wait_proc_enable", bus.proc_enable, 0);
    tick();

    vsync_n = 1'b0; swaps = 0;
    for (int i = 0; i < 12 && swaps == 0; i++) obs(drops, swaps);
    vsync_n = 1'b1;
    chk("swap_seen", swaps, 1);
    @(negedge clk);
    chk("swap_display_bank", display_bank, 1);
    chk("swap_fb_wr_bank", bus.fb_wr_bank, 0);
    chk("swap_to_clear_wren", bus.fb_wren, 1);
    chk("swap_busy", busy, 1);
    chk("swap_error_cleared", error, 0);
    chk("swap_single_pulse", swap_done, 0);
    tick();

    // run 2: watchdog expiry
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.proc_enable) break;
      tick();
    end
    chk("to_reached_process", bus.proc_enable, 1);
    pcyc = 1; first_idle = 0; swaps = 0;
    for (int i = 0; i < 60; i++) begin
      tick(); pcyc++;
      @(negedge clk);
      if (swap_done) swaps++;
      if (!busy) begin first_idle = pcyc; break; end
    end
    chk("to_cycle", first_idle, TMO + 1);
    chk("to_error", error, 1);
    chk("to_display_bank", display_bank, 1);
    chk("to_no_swap", swaps, 0);
    chk("to_proc_enable", bus.proc_enable, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("to_error_sticky_idle", error, 1);
    tick();

    // reset during CLEAR
    start_req = 1'b1; tick(); start_req = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("clr2_wren", bus.fb_wren, 1);
    chk("clr2_error_cleared", error, 0);
    tick(); reset = 1'b1; #2;
    chk("arst_clear_wren", bus.fb_wren, 0);
    chk("arst_clear_busy", busy, 0);
    chk("arst_clear_display", display_bank, 0);
    chk("arst_clear_bank", bus.fb_wr_bank, 1);
    tick(); reset = 1'b0;
    tick();

    // reset during WAIT_VSYNC
    start_req = 1'b1; tick(); start_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.proc_enable) break;
      tick();
    end
    tick(); bus.proc_done = 1'b1; tick(); bus.proc_done = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("wait2_busy", busy, 1);
    tick(); reset = 1'b1; #2;
    chk("arst_wait_busy", busy, 0);
    chk("arst_wait_swap", swap_done, 0);
    chk("arst_wait_display", display_bank, 0);
    chk("arst_wait_enable", bus.proc_enable, 0);
    tick(); reset = 1'b0;
    swaps = 0;
    for (int i = 0; i < 10; i++) obs(drops, swaps);
    chk("arst_wait_no_swap", swaps, 0);

    // randomized traffic
    vper = $urandom_range(40, 90); vcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      start_req     = ($urandom_range(0, 39) == 0);
      bus.proc_done = ($urandom_range(0, 24) == 0);
      bus.proc_wren = 1'($urandom_range(0, 1));
      bus.proc_addr = 5'($urandom_range(0, 31));
      bus.proc_data = 8'($urandom);
      vsync_n = (vcnt >= 3);
      vcnt++;
      if (vcnt >= vper) begin vcnt = 0; vper = $urandom_range(40, 90); end
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    start_req = 1'b0; bus.proc_done = 1'b0; bus.proc_wren = 1'b0; reset = 1'b0; vsync_n = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_swap_scheduler.md
Name: frame_swap_scheduler

Overview:
- Double-buffer manager for the VGA frame buffer. It sequences each processing run as clear back bank → run image processor → wait for vertical sync → swap banks.
- It owns the frame-buffer write port and muxes the clear engine against the processor's write stream.
- It sits between the main controller FSM (start requests), the image processor (enable/done/write stream), the frame-buffer RAM (write port plus bank select) and the VGA display path (display bank select).

Parameters:
- ADDR_W, 19, frame-buffer word address width (per bank).
- DATA_W, 8, pixel width.
- FB_WORDS, 307200, valid words per bank (640x480). Addresses >= FB_WORDS are illegal.
- CLEAR_VALUE, 8'h00, pixel value written during clear.
- TIMEOUT, 2000000, maximum PROCESS cycles before abort.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- start_req  in  1  one-cycle request for a new processing run.
- vsync_n  in  1  raw VGA vsync, active-low, from the 25 MHz domain.
- proc_done  in  1  processor finished (level or pulse).
- proc_wren  in  1  processor write strobe.
- proc_addr  in  ADDR_W  processor write address.
- proc_data  in  DATA_W  processor write pixel.
- proc_enable  out  1  processor run enable.
- fb_wren  out  1  frame-buffer write enable.
- fb_wr_bank  out  1  bank being written (back bank).
- fb_wraddr  out  ADDR_W  frame-buffer write address.
- fb_data  out  DATA_W  frame-buffer write data.
- display_bank  out  1  bank read by VGA (front bank).
- busy  out  1  high in any state other than IDLE.
- swap_done  out  1  one-cycle pulse on bank swap.
- req_dropped  out  1  one-cycle pulse when a start request is discarded.
- error  out  1  sticky: timeout or out-of-range write; cleared on the next accepted start.

Behaviour:
- Reset (async) values:
  - State IDLE, display_bank=0, fb_wr_bank=1.
  - Pending flag, clear counter and watchdog all 0.
  - All other outputs 0.
  - Reset mid-run abandons the run; no swap occurs.
- Invariant: fb_wr_bank is always ~display_bank.
- States: IDLE, CLEAR, PROCESS, WAIT_VSYNC, SWAP.
- IDLE:
  - start_req or pending → CLEAR next cycle.
  - Pending is cleared and error is cleared.
- CLEAR:
  - Clear counter runs 0..FB_WORDS-1, one word per cycle.
  - fb_wren=1, fb_wraddr=counter, fb_data=CLEAR_VALUE.
  - First clear write occurs in the cycle after start_req is sampled.
  - After the write to FB_WORDS-1 → PROCESS. CLEAR lasts exactly FB_WORDS cycles.
- PROCESS:
  - proc_enable=1, registered.
  - Write port is a combinational passthrough: fb_wren=proc_wren, fb_wraddr=proc_addr, fb_data=proc_data (zero latency).
  - proc_wren with proc_addr >= FB_WORDS: write suppressed (fb_wren=0) and error set.
  - proc_done=1 → WAIT_VSYNC; proc_enable falls on the next edge.
  - Watchdog counts cycles in PROCESS. Reaching TIMEOUT → error=1, back to IDLE, no swap, pending retained.
  - proc_wren outside PROCESS is ignored.
- WAIT_VSYNC:
  - vsync_n passes through a 2-FF synchronizer; the falling edge (start of vsync) is detected in the CLOCK_50 domain.
  - Detected edge → SWAP.
  - Worst-case wait is one frame (~16.7 ms).
- SWAP:
  - Lasts one cycle: display_bank toggles, swap_done=1.
  - Next state is CLEAR if pending (pending cleared), else IDLE.
- start_req handling in a busy state (CLEAR, PROCESS, WAIT_VSYNC, SWAP):
  - If pending=0: set pending.
  - If pending=1: req_dropped pulses; the queue depth is 1.
  - start_req in the SWAP cycle sets pending and is honoured by the same-cycle transition to CLEAR.
- Counter widths:
  - Clear counter is ADDR_W bits and never wraps: terminal compare against FB_WORDS-1.
  - Watchdog is ceil(log2(TIMEOUT+1)) bits, saturating.
- Outputs busy and display_bank are registered. fb_* outputs are registered in CLEAR and passthrough in PROCESS.

Decomposition:
- Package fb_sched_pkg:
  - State enum (IDLE, CLEAR, PROCESS, WAIT_VSYNC, SWAP).
  - Default FB_WORDS and CLEAR_VALUE constants.
  - Bank-select encoding.
- Sub-module vsync_edge_sync: 2-FF synchronizer plus falling-edge detector, async reset to "vsync inactive" (synchronized level 1).

Test Plan:
- FB_WORDS=16, start_req at cycle 0 → fb_wren=1 for cycles 1..16, addresses 0..15, data 0x00, fb_wr_bank=1. proc_enable=1 from cycle 17.
- In PROCESS: proc_wren with addr 5, data 0xA7 → fb_wren=1, fb_wraddr=5, fb_data=0xA7 in the same cycle. Assert proc_done, then a vsync_n falling edge → swap_done pulses once, display_bank=1, busy=0.
- Three start_req pulses during PROCESS → req_dropped pulses exactly twice. After the swap, state returns to CLEAR with fb_wr_bank=0.
- proc_wren with addr 16 (FB_WORDS=16) → fb_wren=0, error=1. error stays 1 until the next accepted start_req.
- TIMEOUT=50 with proc_done held 0 → after 50 PROCESS cycles: error=1, IDLE, display_bank unchanged, no swap_done.
- Assert reset during CLEAR and during WAIT_VSYNC → all outputs return to reset values immediately (async). Display_bank=0, no swap_done pulse.
